mos6502_fetch_unit: RTL and testbench

- Parametrised instruction-fetch front end for the NES 6502 core.
- Runs the reset-vector sequence, then fetches the opcode and 0–2 operand bytes per instruction on the external byte bus, honouring the RDY wait line.
- Presents each complete instruction to the execute stage through a valid/ready handshake.
- Accepts a PC redirect from execute for jumps, branches and interrupts.

---
 rtl/mos6502_pkg.sv | 56 +++++
 rtl/mos6502_fetch_unit_if.sv | 33 +++
 rtl/mos6502_len_decode.sv | 17 +
 rtl/mos6502_fetch_unit.sv | 159 +++++++++++++++
 tb/tb_mos6502_fetch_unit.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mos6502_pkg.sv
`default_nettype none
// ============================================================================
// Module : mos6502_pkg
// Brief  : Shared fetch-state encoding, reset-vector default and opcode
//          length decode for the NES 6502 front end.
// Rev    : 1.0  initial release
// ============================================================================
package mos6502_pkg;

  typedef enum logic [2:0] {
    VEC_LO = 3'd0,
    VEC_HI = 3'd1,
    OPC    = 3'd2,
    OP1    = 3'd3,
    OP2    = 3'd4,
    DONE   = 3'd5
  } fetch_state_t;

  localparam logic [15:0] RESET_VEC_DEFAULT = 16'hFFFC;

  // Instruction length from the aaa/bbb/cc opcode fields; first match wins.
  function automatic logic [1:0] instr_length(input logic [7:0] op);
    logic [2:0] aaa;
    logic [2:0] bbb;
    logic [1:0] cc;
    logic [1:0] len;
    aaa = op[7:5];
    bbb = op[4:2];
    cc  = op[1:0];
    len = 2'd1;
    if (op == 8'h20) begin
      len = 2'd3;
    end else if (op == 8'h00 || op == 8'h40 || op == 8'h60) begin
      len = 2'd1;
    end else begin
      case (bbb)
        3'b000: begin
          if (cc == 2'b01)                        len = 2'd2;
          else if (cc == 2'b00 && aaa >= 3'd5)    len = 2'd2;
          else if (cc == 2'b10 && aaa == 3'd5)    len = 2'd2;
          else                                    len = 2'd1;
        end
        3'b001:  len = 2'd2;
        3'b010:  len = (cc == 2'b01) ? 2'd2 : 2'd1;
        3'b011:  len = 2'd3;
        3'b100:  len = (cc == 2'b00 || cc == 2'b01) ? 2'd2 : 2'd1;
        3'b101:  len = 2'd2;
        3'b110:  len = (cc == 2'b01) ? 2'd3 : 2'd1;
        default: len = 2'd3;
      endcase
    end
    return len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mos6502_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module : mos6502_fetch_unit_if
// Brief  : External byte bus, redirect and execute-stage handshake bundle.
// Rev    : 1.0  initial release
// ============================================================================
interface mos6502_fetch_unit_if #(
  parameter int ADDR_W = 16
);
  logic [7:0]        din;
  logic              rdy;
  logic [ADDR_W-1:0] addr;
  logic              rd_en;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic [7:0]        instr_opcode;
  logic [15:0]       instr_operand;
  logic [1:0]        instr_len;
  logic [ADDR_W-1:0] instr_pc;

  modport master (
    input  din, rdy, redirect, redirect_pc, instr_ready,
    output addr, rd_en, instr_valid, instr_opcode, instr_operand, instr_len, instr_pc
  );

  modport slave (
    output din, rdy, redirect, redirect_pc, instr_ready,
    input  addr, rd_en, instr_valid, instr_opcode, instr_operand, instr_len, instr_pc
  );
endinterface
`default_nettype wire

// File: rtl/mos6502_len_decode.sv
`default_nettype none
// ============================================================================
// Module : mos6502_len_decode
// Brief  : Combinational opcode-to-length decoder (1, 2 or 3 bytes).
// Rev    : 1.0  initial release
// ============================================================================
module mos6502_len_decode
  import mos6502_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [1:0] len
);

  assign len = instr_length(opcode);

endmodule
`default_nettype wire

// File: rtl/mos6502_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : mos6502_fetch_unit
// Brief  : 6502 instruction fetch front end: reset vector, opcode/operand
//          fetch over an RDY-stretched byte bus, valid/ready to execute.
//          Optional macro FETCH_SYNC_EN adds sync and fetch_count outputs.
// Rev    : 1.0  initial release
// ============================================================================
module mos6502_fetch_unit
  import mos6502_pkg::*;
#(
  parameter int          ADDR_W    = 16,
  parameter logic [15:0] RESET_VEC = RESET_VEC_DEFAULT
) (
  input  logic clk,
  input  logic nrst,
  mos6502_fetch_unit_if.master bus
`ifdef FETCH_SYNC_EN
  ,
  output logic        sync,
  output logic [15:0] fetch_count
`endif
);

  localparam logic [ADDR_W-1:0] c_addr_one = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] c_vec_lo   = RESET_VEC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] c_vec_hi   = c_vec_lo + c_addr_one;

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rd_en;
  logic [7:0]        r_vec_lo;
  logic [7:0]        r_opcode;
  logic [15:0]       r_operand;
  logic [1:0]        r_len;
  logic [ADDR_W-1:0] r_pc;
  logic              r_valid;

  logic [1:0]        w_len;
  logic              w_bus_done;
  logic              w_accept;
  logic              w_redirect;
  logic [15:0]       w_vector16;
  logic [ADDR_W-1:0] w_vector;
  logic [ADDR_W-1:0] w_next_pc;

  mos6502_len_decode u_len_decode (
    .opcode (bus.din),
    .len    (w_len)
  );

  assign w_bus_done = r_rd_en & bus.rdy;
  assign w_accept   = r_valid & bus.instr_ready;
  // Redirects are meaningless before the vector is known.
  assign w_redirect = bus.redirect & (r_state != VEC_LO) & (r_state != VEC_HI);
  assign w_vector16 = {bus.din, r_vec_lo};
  assign w_vector   = w_vector16[ADDR_W-1:0];
  assign w_next_pc  = r_pc + {{(ADDR_W-2){1'b0}}, r_len};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= VEC_LO;
      r_addr    <= c_vec_lo;
      r_rd_en   <= 1'b1;
      r_vec_lo  <= 8'h00;
      r_opcode  <= 8'h00;
      r_operand <= 16'h0000;
      r_len     <= 2'd0;
      r_pc      <= '0;
      r_valid   <= 1'b0;
    end else if (w_redirect) begin
      r_state <= OPC;
      r_addr  <= bus.redirect_pc;
      r_rd_en <= 1'b1;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        VEC_LO: if (w_bus_done) begin
          r_vec_lo <= bus.din;
          r_addr   <= c_vec_hi;
          r_state  <= VEC_HI;
        end
        VEC_HI: if (w_bus_done) begin
          r_addr  <= w_vector;
          r_state <= OPC;
        end
        OPC: if (w_bus_done) begin
          r_opcode  <= bus.din;
          r_operand <= 16'h0000;
          r_pc      <= r_addr;
          r_len     <= w_len;
          if (w_len == 2'd1) begin
            r_rd_en <= 1'b0;
            r_valid <= 1'b1;
            r_state <= DONE;
          end else begin
            r_addr  <= r_addr + c_addr_one;
            r_state <= OP1;
          end
        end
        OP1: if (w_bus_done) begin
          r_operand[7:0] <= bus.din;
          if (r_len == 2'd2) begin
            r_rd_en <= 1'b0;
            r_valid <= 1'b1;
            r_state <= DONE;
          end else begin
            r_addr  <= r_addr + c_addr_one;
            r_state <= OP2;
          end
        end
        OP2: if (w_bus_done) begin
          r_operand[15:8] <= bus.din;
          r_rd_en         <= 1'b0;
          r_valid         <= 1'b1;
          r_state         <= DONE;
        end
        DONE: if (w_accept) begin
          r_addr  <= w_next_pc;
          r_rd_en <= 1'b1;
          r_valid <= 1'b0;
          r_state <= OPC;
        end
        default: begin
          r_state <= VEC_LO;
          r_addr  <= c_vec_lo;
          r_rd_en <= 1'b1;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.addr          = r_addr;
  assign bus.rd_en         = r_rd_en;
  assign bus.instr_valid   = r_valid;
  assign bus.instr_opcode  = r_opcode;
  assign bus.instr_operand = r_operand;
  assign bus.instr_len     = r_len;
  assign bus.instr_pc      = r_pc;

`ifdef FETCH_SYNC_EN
  logic [15:0] r_fetch_count;

  // An accepted record is counted even when a redirect lands on the same edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_fetch_count <= 16'h0000;
    end else if (w_accept) begin
      r_fetch_count <= r_fetch_count + 16'h0001;
    end
  end

  assign sync        = (r_state == OPC) & r_rd_en;
  assign fetch_count = r_fetch_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mos6502_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_mos6502_fetch_unit
// Brief  : Self-checking bench: directed scenarios plus randomized stream
//          against a memory-image reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mos6502_fetch_unit;

  localparam int ADDR_W = 16;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  mos6502_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

  logic [7:0] mem [0:65535];
  assign bus.din = mem[bus.addr];

`ifdef FETCH_SYNC_EN
  logic        sync_w;
  logic [15:0] fetch_count_w;
`endif

  mos6502_fetch_unit #(.ADDR_W(ADDR_W), .RESET_VEC(16'hFFFC)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
`ifdef FETCH_SYNC_EN
    ,
    .sync        (sync_w),
    .fetch_count (fetch_count_w)
`endif
  );

  logic [7:0] dec_op;
  logic [1:0] dec_len;
  mos6502_len_decode u_dec (.opcode(dec_op), .len(dec_len));

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] bus_log [$];
  always @(posedge clk) if (nrst && bus.rd_en && bus.rdy) bus_log.push_back(bus.addr);

  // Length by addressing-mode column (bbb) and group (cc); bbb=000 handled apart.
  int len_tbl [8][4] = '{'{0,0,0,0}, '{2,2,2,2}, '{1,2,1,1}, '{3,3,3,3},
                         '{2,2,1,1}, '{2,2,2,2}, '{1,3,1,1}, '{3,3,3,3}};

  function automatic int ref_len(input logic [7:0] op);
    int a, b, c;
    a = int'(op[7:5]);
    b = int'(op[4:2]);
    c = int'(op[1:0]);
    if (op == 8'h20) return 3;
    if (b != 0) return len_tbl[b][c];
    if (c == 1) return 2;
    if (c == 0) return (a >= 5) ? 2 : 1;
    if (c == 2) return (a == 5) ? 2 : 1;
    return 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_mem(input logic [7:0] fill);
    for (int i = 0; i < 65536; i++) mem[i] = fill;
  endtask

  task automatic apply_reset();
    nrst = 1'b0;
    bus.rdy = 1'b1;
    bus.instr_ready = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    tick();
    tick();
    nrst = 1'b1;
    bus_log.delete();
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.instr_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_addr(input logic [15:0] target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.addr === target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    tick();
    tick();
    n_checks++; if (bus.addr !== 16'hFFFC) begin n_fail++; $display("FAIL reset_addr: got %h want fffc", bus.addr); end
    n_checks++; if (bus.rd_en !== 1'b1) begin n_fail++; $display("FAIL reset_rd_en: got %b want 1", bus.rd_en); end
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.instr_valid); end
    n_checks++;
    if ({bus.instr_opcode, bus.instr_operand, bus.instr_len, bus.instr_pc} !== 42'h0) begin
      n_fail++; $display("FAIL reset_record: got op=%h opd=%h len=%0d pc=%h want all 0",
                         bus.instr_opcode, bus.instr_operand, bus.instr_len, bus.instr_pc);
    end
  endtask

  task automatic test_basic();
    bit ok;
    init_mem(8'hEA);
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
    mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h42;
    apply_reset();
    wait_valid(20, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_timeout: got no valid want valid"); end
    n_checks++;
    if (bus_log.size() < 4 || bus_log[0] !== 16'hFFFC || bus_log[1] !== 16'hFFFD ||
        bus_log[2] !== 16'h8000 || bus_log[3] !== 16'h8001) begin
      n_fail++; $display("FAIL basic_addr_seq: got %0d reads want fffc fffd 8000 8001", bus_log.size());
    end
    n_checks++;
    if (bus.instr_opcode !== 8'hA9 || bus.instr_operand !== 16'h0042 || bus.instr_len !== 2'd2 || bus.instr_pc !== 16'h8000) begin
      n_fail++; $display("FAIL basic_record: got %h %h %0d %h want a9 0042 2 8000",
                         bus.instr_opcode, bus.instr_operand, bus.instr_len, bus.instr_pc);
    end
    n_checks++; if (bus.rd_en !== 1'b0) begin n_fail++; $display("FAIL basic_rd_en_done: got %b want 0", bus.rd_en); end
  endtask

  task automatic test_hold();
    bit ok;
    init_mem(8'hEA);
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
    mem[16'h8000] = 8'hAD; mem[16'h8001] = 8'h34; mem[16'h8002] = 8'h12;
    apply_reset();
    wait_valid(20, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL hold_timeout: got no valid want valid"); end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr_opcode !== 8'hAD || bus.instr_operand !== 16'h1234 ||
          bus.instr_len !== 2'd3 || bus.instr_pc !== 16'h8000) begin
        n_fail++; $display("FAIL hold_record[%0d]: got v=%b %h %h %0d %h want 1 ad 1234 3 8000", k,
                           bus.instr_valid, bus.instr_opcode, bus.instr_operand, bus.instr_len, bus.instr_pc);
      end
      if (k < 3) tick();
    end
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    n_checks++;
    if (bus.addr !== 16'h8003 || bus.rd_en !== 1'b1 || bus.instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL hold_next_addr: got %h rd=%b v=%b want 8003 1 0", bus.addr, bus.rd_en, bus.instr_valid);
    end
    wait_valid(20, ok);
    n_checks++;
    if (ok !== 1'b1 || bus.instr_opcode !== 8'hEA || bus.instr_len !== 2'd1 ||
        bus.instr_operand !== 16'h0000 || bus.instr_pc !== 16'h8003) begin
      n_fail++; $display("FAIL hold_nop: got %h %0d %h %h want ea 1 0000 8003",
                         bus.instr_opcode, bus.instr_len, bus.instr_operand, bus.instr_pc);
    end
  endtask

  task automatic test_rdy_stall();
    bit ok;
    init_mem(8'hEA);
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
    mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h42;
    apply_reset();
    wait_addr(16'h8001, 20, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL stall_reach_op1: got %h want 8001", bus.addr); end
    bus.rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (bus.addr !== 16'h8001 || bus.instr_valid !== 1'b0 || bus.rd_en !== 1'b1) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got %h v=%b rd=%b want 8001 0 1", k, bus.addr, bus.instr_valid, bus.rd_en);
      end
    end
    bus.rdy = 1'b1;
    tick();
    n_checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_operand !== 16'h0042 || bus.instr_len !== 2'd2) begin
      n_fail++; $display("FAIL stall_release: got v=%b %h %0d want 1 0042 2", bus.instr_valid, bus.instr_operand, bus.instr_len);
    end
  endtask

  task automatic test_redirect();
    bit ok;
    init_mem(8'hEA);
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
    mem[16'h8000] = 8'hAD; mem[16'h8001] = 8'h34; mem[16'h8002] = 8'h12;
    apply_reset();
    wait_addr(16'h8001, 20, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL redir_reach_op1: got %h want 8001", bus.addr); end
    bus.redirect = 1'b1;
    bus.redirect_pc = 16'hC000;
    tick();
    bus.redirect = 1'b0;
    n_checks++;
    if (bus.addr !== 16'hC000 || bus.instr_valid !== 1'b0 || bus.rd_en !== 1'b1) begin
      n_fail++; $display("FAIL redir_addr: got %h v=%b rd=%b want c000 0 1", bus.addr, bus.instr_valid, bus.rd_en);
    end
    wait_valid(20, ok);
    n_checks++;
    if (ok !== 1'b1 || bus.instr_pc !== 16'hC000 || bus.instr_opcode !== 8'hEA) begin
      n_fail++; $display("FAIL redir_first_record: got pc=%h op=%h want c000 ea", bus.instr_pc, bus.instr_opcode);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    init_mem(8'hEA);
    mem[16'hFFFC] = 8'hFE; mem[16'hFFFD] = 8'hFF;
    mem[16'hFFFE] = 8'h20; mem[16'hFFFF] = 8'h34; mem[16'h0000] = 8'h12;
    apply_reset();
    wait_valid(20, ok);
    n_checks++;
    if (ok !== 1'b1 || bus.instr_opcode !== 8'h20 || bus.instr_operand !== 16'h1234 ||
        bus.instr_len !== 2'd3 || bus.instr_pc !== 16'hFFFE) begin
      n_fail++; $display("FAIL wrap_record: got %h %h %0d %h want 20 1234 3 fffe",
                         bus.instr_opcode, bus.instr_operand, bus.instr_len, bus.instr_pc);
    end
    n_checks++;
    if (bus_log.size() < 5 || bus_log[3] !== 16'hFFFF || bus_log[4] !== 16'h0000) begin
      n_fail++; $display("FAIL wrap_operand_addrs: got %0d reads want ..fffe ffff 0000", bus_log.size());
    end
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    n_checks++; if (bus.addr !== 16'h0001) begin n_fail++; $display("FAIL wrap_next_addr: got %h want 0001", bus.addr); end
    apply_reset();
    wait_addr(16'h0000, 20, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL wrap_reach_op2: got %h want 0000", bus.addr); end
    bus.rdy = 1'b0;
    #2;
    nrst = 1'b0;
    #1;
    n_checks++;
    if (bus.addr !== 16'hFFFC || bus.instr_valid !== 1'b0 || bus.rd_en !== 1'b1 || bus.instr_opcode !== 8'h00) begin
      n_fail++; $display("FAIL wrap_async_reset: got %h v=%b rd=%b op=%h want fffc 0 1 00",
                         bus.addr, bus.instr_valid, bus.rd_en, bus.instr_opcode);
    end
    bus.rdy = 1'b1;
    tick();
    nrst = 1'b1;
    bus_log.delete();
    wait_valid(20, ok);
    n_checks++;
    if (ok !== 1'b1 || bus.instr_pc !== 16'hFFFE || bus.instr_opcode !== 8'h20) begin
      n_fail++; $display("FAIL wrap_after_reset: got pc=%h op=%h want fffe 20", bus.instr_pc, bus.instr_opcode);
    end
  endtask

  task automatic test_len_sweep();
    logic [7:0] spot_op  [7] = '{8'h00, 8'h09, 8'h0A, 8'h10, 8'h6C, 8'hB9, 8'hBE};
    int         spot_len [7] = '{1, 2, 1, 2, 3, 3, 3};
    for (int op = 0; op < 256; op++) begin
      dec_op = 8'(op);
      #1;
      n_checks++;
      if (int'(dec_len) !== ref_len(dec_op)) begin
        n_fail++; $display("FAIL len_sweep[%h]: got %0d want %0d", dec_op, dec_len, ref_len(dec_op));
      end
    end
    for (int k = 0; k < 7; k++) begin
      dec_op = spot_op[k];
      #1;
      n_checks++;
      if (int'(dec_len) !== spot_len[k]) begin
        n_fail++; $display("FAIL len_spot[%h]: got %0d want %0d", dec_op, dec_len, spot_len[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] exp_pc;
    logic [15:0] p1, p2;
    logic [7:0]  e_op;
    logic [15:0] e_opd;
    int          e_len;
    int          accepted;
    bit          armed;
    bit          have_prev;
    logic [41:0] prev_rec;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    apply_reset();
    exp_pc = {mem[16'hFFFD], mem[16'hFFFC]};
    accepted = 0;
    armed = 1'b0;
    have_prev = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (have_prev) begin
        n_checks++;
        if (bus.instr_valid !== 1'b1 ||
            {bus.instr_opcode, bus.instr_operand, bus.instr_len, bus.instr_pc} !== prev_rec) begin
          n_fail++; $display("FAIL rand_stable: got v=%b %h %h %0d %h while held", bus.instr_valid,
                             bus.instr_opcode, bus.instr_operand, bus.instr_len, bus.instr_pc);
        end
      end
      if (bus.instr_valid === 1'b1) armed = 1'b1;
      bus.rdy         = ($urandom_range(0, 9) < 7);
      bus.instr_ready = ($urandom_range(0, 3) != 0);
      bus.redirect    = armed && ($urandom_range(0, 39) == 0);
      bus.redirect_pc = 16'($urandom);
      if (bus.instr_valid === 1'b1 && bus.instr_ready) begin
        p1 = exp_pc + 16'd1;
        p2 = exp_pc + 16'd2;
        e_op  = mem[exp_pc];
        e_len = ref_len(e_op);
        e_opd = 16'h0000;
        if (e_len >= 2) e_opd[7:0]  = mem[p1];
        if (e_len == 3) e_opd[15:8] = mem[p2];
        n_checks++;
        if (bus.instr_opcode !== e_op || bus.instr_operand !== e_opd ||
            int'(bus.instr_len) !== e_len || bus.instr_pc !== exp_pc) begin
          n_fail++; $display("FAIL rand_record: got %h %h %0d %h want %h %h %0d %h",
                             bus.instr_opcode, bus.instr_operand, bus.instr_len, bus.instr_pc,
                             e_op, e_opd, e_len, exp_pc);
        end
        accepted++;
        exp_pc = exp_pc + 16'(e_len);
      end
      have_prev = (bus.instr_valid === 1'b1) && !bus.instr_ready && !bus.redirect;
      prev_rec  = {bus.instr_opcode, bus.instr_operand, bus.instr_len, bus.instr_pc};
      if (bus.redirect) exp_pc = bus.redirect_pc;
      tick();
    end
    bus.redirect = 1'b0;
    bus.instr_ready = 1'b0;
    bus.rdy = 1'b1;
    n_checks++;
    if (accepted < 100) begin n_fail++; $display("FAIL rand_progress: got %0d accepted want >= 100", accepted); end
  endtask

  initial begin
    bus.rdy = 1'b1;
    bus.instr_ready = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    dec_op = 8'h00;
    init_mem(8'hEA);
    test_reset();
    test_basic();
    test_hold();
    test_rdy_stall();
    test_redirect();
    test_wrap();
    test_len_sweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
